// File: rtl/lfsr_rng_bank.sv
// Bank of independent maximal-length Fibonacci LFSRs with a request/valid
// bounded-draw engine (rejection sampling, modulo fallback after MAX_TRIES).
module lfsr_rng_bank #(
    parameter int WIDTH     = 9,
    parameter int CHANNELS  = 4,
    parameter int OUT_W     = 4,
    parameter int MAX_TRIES = 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [CHANNELS-1:0]       Step,
    input  logic                      Load,
    input  logic [CH_W-1:0]           Load_ch,
    input  logic [WIDTH-1:0]          Seed,
    input  logic                      Req,
    input  logic [CH_W-1:0]           Req_ch,
    input  logic [OUT_W-1:0]          Limit,
    output logic [CHANNELS*WIDTH-1:0] State,
    output logic [OUT_W-1:0]          Rand,
    output logic                      Valid,
    output logic                      Busy
);

    // Bit (WIDTH - t) is set for every exponent t of the tap polynomial.
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            4:       return 16'h0003;
            5:       return 16'h0005;
            6:       return 16'h0003;
            7:       return 16'h0003;
            8:       return 16'h001D;
            9:       return 16'h0011;
            10:      return 16'h0009;
            11:      return 16'h0005;
            12:      return 16'h0107;
            13:      return 16'h0027;
            14:      return 16'h1007;
            15:      return 16'h0003;
            16:      return 16'h100B;
            default: return 16'h0003;
        endcase
    endfunction

    localparam logic [15:0] TAPS = tap_mask(WIDTH);

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {^(s & TAPS[WIDTH-1:0]), s[WIDTH-1:1]};
    endfunction

    typedef enum logic {IDLE, DRAW} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [OUT_W:0]   lim_q, lim_d;
    logic [7:0]       tries_q, tries_d;
    logic [OUT_W-1:0] rand_d;
    logic             valid_d;
    logic             draw_step;
    logic [OUT_W-1:0] cand;
    logic [OUT_W:0]   rem;

    logic [WIDTH-1:0] lfsr_q [CHANNELS];
    logic [WIDTH-1:0] lfsr_d [CHANNELS];

    assign cand = lfsr_q[ch_q][OUT_W-1:0];
    assign rem  = {1'b0, cand} % lim_q;
    assign Busy = (fsm_q == DRAW);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        fsm_d     = fsm_q;
        ch_d      = ch_q;
        lim_d     = lim_q;
        tries_d   = tries_q;
        rand_d    = Rand;
        valid_d   = 1'b0;
        draw_step = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (Req) begin
                    ch_d    = (int'(Req_ch) < CHANNELS) ? Req_ch : '0;
                    lim_d   = (Limit == '0) ? {1'b1, {OUT_W{1'b0}}} : {1'b0, Limit};
                    tries_d = '0;
                    fsm_d   = DRAW;
                end
            end
            DRAW: begin
                draw_step = 1'b1;
                if ({1'b0, cand} < lim_q) begin
                    rand_d  = cand;
                    valid_d = 1'b1;
                    fsm_d   = IDLE;
                end else if (tries_q == 8'(MAX_TRIES)) begin
                    rand_d  = rem[OUT_W-1:0];
                    valid_d = 1'b1;
                    fsm_d   = IDLE;
                end else begin
                    tries_d = tries_q + 8'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Load beats the draw-step, which beats the external Step on the same channel.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            lfsr_d[c] = lfsr_q[c];
            if (Load && Load_ch == CH_W'(c))
                lfsr_d[c] = (Seed == '0) ? WIDTH'(1) : Seed;
            else if (draw_step && ch_q == CH_W'(c))
                lfsr_d[c] = lfsr_next(lfsr_q[c]);
            else if (Step[c])
                lfsr_d[c] = lfsr_next(lfsr_q[c]);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm_q   <= IDLE;
            ch_q    <= '0;
            lim_q   <= {{OUT_W{1'b0}}, 1'b1};
            tries_q <= '0;
            Rand    <= '0;
            Valid   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                lfsr_q[c] <= WIDTH'(c + 1);
        end else begin
            // NOTE: non-blocking updates so all registers sample pre-edge values.
            fsm_q   <= fsm_d;
            ch_q    <= ch_d;
            lim_q   <= lim_d;
            tries_q <= tries_d;
            Rand    <= rand_d;
            Valid   <= valid_d;
            for (int c = 0; c < CHANNELS; c++)
                lfsr_q[c] <= lfsr_d[c];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_state
        assign State[g*WIDTH +: WIDTH] = lfsr_q[g];
    end

endmodule

// File: doc/lfsr_rng_bank.md
# lfsr_rng_bank

Multi-channel, parametrised Fibonacci LFSR pseudo-random bank with a bounded-draw engine. It serves the game logic, for example ghost direction choice and fruit timing. Each channel is an independent maximal-length LFSR that can be seeded and stepped on its own. A request/valid handshake returns a value in [0, Limit) using rejection sampling, with a modulo fallback after a bounded number of rejections.

## Interface
- WIDTH, default 9: LFSR width per channel, legal range 4..16.
- CHANNELS, default 4: number of independent LFSRs, 1..2^WIDTH−1.
- OUT_W, default 4: width of the bounded random output, 1..min(8, WIDTH).
- MAX_TRIES, default 8: maximum rejections before fallback, 0..255.
- CH_W, derived: max(1, $clog2(CHANNELS)).

Ports:
- Clk  in  1  sole clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Step  in  CHANNELS  per-channel advance enable, one state per cycle.
- Load  in  1  seed-load strobe.
- Load_ch  in  CH_W  channel targeted by Load.
- Seed  in  WIDTH  seed value.
- Req  in  1  bounded-draw request.
- Req_ch  in  CH_W  channel used for the draw.
- Limit  in  OUT_W  exclusive upper bound; 0 means 2^OUT_W.
- State  out  CHANNELS*WIDTH  flat state; channel c occupies bits [c*WIDTH +: WIDTH].
- Rand  out  OUT_W  draw result, held until the next Valid.
- Valid  out  1  one-cycle pulse, Rand is new.
- Busy  out  1  draw in progress.

## Operation
- **Step rule** (s = channel state): next = {fb, s[WIDTH−1:1]}. fb = XOR of s[WIDTH−t] over each exponent t of the tap polynomial.
- **Tap polynomials** (t includes WIDTH):
  - 4: x4+x3+1
  - 5: x5+x3+1
  - 6: x6+x5+1
  - 7: x7+x6+1
  - 8: x8+x6+x5+x4+1
  - 9: x9+x5+1
  - 10: x10+x7+1
  - 11: x11+x9+1
  - 12: x12+x11+x10+x4+1
  - 13: x13+x12+x11+x8+1
  - 14: x14+x13+x12+x2+1
  - 15: x15+x14+1
  - 16: x16+x15+x13+x4+1
- **Period:** every channel has period 2^WIDTH−1; all-zero is never reachable.
- **Reset:** channel c = c+1; Rand=0, Valid=0, Busy=0, FSM=IDLE, tries=0.
- **Load:** channel Load_ch takes Seed. A Seed of 0 loads 1 (lockup guard). Load_ch ≥ CHANNELS is ignored.
- **Per-channel priority:** Load > draw-step > Step. Step on the channel currently being drawn is ignored.
- **FSM states:** IDLE, DRAW.
  - IDLE: Req=1 latches ch (Req_ch ≥ CHANNELS maps to 0), L (Limit, with 0 read as 2^OUT_W) and tries=0, then moves to DRAW.
  - DRAW, evaluated each cycle: cand = s_ch[OUT_W−1:0].
    - cand < L: Rand←cand, Valid←1, step ch, go to IDLE.
    - else if tries == MAX_TRIES: Rand←cand mod L, Valid←1, step ch, go to IDLE.
    - else: step ch, tries++, stay in DRAW.
- Load to the active channel mid-draw takes effect. The draw continues from the loaded value next cycle, and tries is not cleared.
- Req while Busy=1 is ignored; no queueing.

## Timing
- **Step/Load:** State reflects the change one edge after the strobe.
- **Busy:** rises at the Req-capture edge E0 and falls at the edge Valid rises, so Busy=0 during the Valid cycle.
- **Valid:** rises at edge E0+1+r, where r = rejections, 0..MAX_TRIES. Worst-case latency is MAX_TRIES+1 edges.
- **Back-to-back draws:** Req high during the Valid cycle is captured, since the FSM is in IDLE.
- **Rand:** registered; changes only at a Valid edge.
- **Reset_n low, any cycle:** all outputs go to reset values immediately and asynchronously; an in-flight draw is abandoned with no Valid. The first draw may be captured at the first rising edge after Reset_n deasserts.

## Test plan
All scenarios use WIDTH=9, CHANNELS=4, OUT_W=4, MAX_TRIES=8 unless noted.
- **Reset:** pulse Reset_n low mid-cycle → State = {4,3,2,1} for ch3..ch0; Rand=0, Valid=0, Busy=0 asynchronously.
- **Period:** Step[0] held high from 0x001 → first next state 0x100; returns to 0x001 after exactly 511 steps, never earlier; other channels unchanged.
- **Zero-seed guard:** Load ch2 with Seed 0 → State ch2 = 0x001; a Load with Load_ch=2 and Step[2] in the same cycle → load wins.
- **Accept on first try:** ch0 loaded with 0x005, Req with Limit=7 → Valid at E0+1, Rand=5, ch0 = 0x102. A second Req while Busy is ignored.
- **Single rejection:** ch0=0x001, Limit=1 → cand 1 rejected, ch0→0x100; cand 0 accepted; Valid at E0+2, Rand=0, ch0=0x080.
- **Fallback:** instance with MAX_TRIES=0, ch1=0x00E, Limit=3 → Valid at E0+1, Rand=2, ch1=0x007. A repeat with Reset_n pulsed at E0+0.5 → no Valid, Busy=0.
